// File: rtl/shift_add_mult8_pkg.sv
// shift_add_mult8_pkg: state encoding and width helper shared by the multiplier set
package shift_add_mult8_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/shift_add_mult8_if.sv
// shift_add_mult8_if: operand/result handshake bundle for the multipliers
interface shift_add_mult8_if #(parameter int WIDTH = 8);
    logic start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic busy;
    logic done;
    logic [2*WIDTH-1:0] p;
    modport master(output start, a, b, input busy, done, p);
    modport slave(input start, a, b, output busy, done, p);
endinterface

// File: rtl/fa.sv
// fa: full-adder cell
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/ha.sv
// ha: half-adder cell
module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/shift_add_mult8_add_cout.sv
// shift_add_mult8_add_cout: WIDTH-bit ripple adder exposing its carry-out
module shift_add_mult8_add_cout #(parameter int WIDTH = 8) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:1] c;
    ha u_ha (.a(a[0]), .b(b[0]), .s(sum[0]), .c(c[1]));
    genvar i;
    generate
        for (i = 1; i < WIDTH; i++) begin : g_fa
            fa u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
        end
    endgenerate
    assign cout = c[WIDTH];
endmodule

// File: rtl/shift_add_mult8.sv
// shift_add_mult8: sequential shift-and-add unsigned multiplier, one add per cycle
module shift_add_mult8
    import shift_add_mult8_pkg::*;
#(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst_n,
    shift_add_mult8_if.slave bus
);
    localparam int CW = clog2(WIDTH + 1);
    state_t state, state_nxt;
    logic [WIDTH-1:0] m, acc, q, sum;
    logic [CW-1:0] cnt;
    logic c, load;
    // masking m with q[0] gives the "acc + m or acc" mux ahead of the adder
    shift_add_mult8_add_cout #(.WIDTH(WIDTH)) u_add (
        .a(acc), .b(m & {WIDTH{q[0]}}), .sum(sum), .cout(c)
    );
    assign load = bus.start && state != ST_BUSY;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = load ? ST_BUSY :
                    state == ST_DONE ? ST_IDLE :
                    (state == ST_BUSY && cnt == CW'(1)) ? ST_DONE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '0;
            acc <= '0;
            q <= '0;
            cnt <= '0;
        end else if (load) begin
            m <= bus.a;
            q <= bus.b;
            acc <= '0;
            cnt <= CW'(WIDTH);
        end else if (state == ST_BUSY) begin
            {acc, q} <= {c, sum, q[WIDTH-1:1]};
            cnt <= cnt - CW'(1);
        end
    end
    assign bus.busy = state == ST_BUSY;
    assign bus.done = state == ST_DONE;
    assign bus.p = {acc, q};
endmodule

// File: tb/tb_shift_add_mult8.sv
// tb_shift_add_mult8: directed vectors with a queue scoreboard checked on every done pulse
module tb_shift_add_mult8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    shift_add_mult8_if #(.WIDTH(8)) bus ();
    shift_add_mult8 #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    logic [15:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask
    always @(negedge clk) begin
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: p=%0h with no product pending", bus.p);
            end else begin
                check("product", {16'h0, bus.p}, {16'h0, exp_q.pop_front()});
            end
        end
    end
    task automatic quiet(input string name);
        int nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check(name, nd, 0);
    endtask
    // mode 0: plain op, 1: stray start at busy cycle 3, 2: reset at busy cycle 4
    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e, input int mode);
        int cyc = 0;
        int nb = 0;
        @(negedge clk);
        if (mode != 2) exp_q.push_back(e);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.start = 1'b0;
                bus.a = 8'($urandom);
                bus.b = 8'($urandom);
            end
            if (mode == 1 && cyc == 3) begin
                bus.start = 1'b1;
                bus.a = 8'h01;
                bus.b = 8'h01;
            end
            if (mode == 1 && cyc == 4) bus.start = 1'b0;
            if (mode == 2 && cyc == 4) begin
                rst_n = 1'b0;
                #1;
                check("abort_busy", {31'h0, bus.busy}, 0);
                check("abort_done", {31'h0, bus.done}, 0);
                check("abort_p", {16'h0, bus.p}, 0);
                @(negedge clk);
                rst_n = 1'b1;
                quiet("abort_no_done");
                return;
            end
            if (bus.done) break;
            if (bus.busy) nb++;
        end
        check("start_to_done", cyc, 9);
        check("busy_cycles", nb, 8);
        if (mode == 1) quiet("no_second_done");
    endtask
    task automatic stream();
        int cyc = 0;
        int nd = 0;
        int last = 0;
        @(negedge clk);
        exp_q.push_back(16'h000F);
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h00FF);
        bus.start = 1'b1;
        bus.a = 8'h03;
        bus.b = 8'h05;
        while (nd < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.a = 8'h80;
                bus.b = 8'h02;
            end
            if (cyc == 10) begin
                bus.a = 8'hFF;
                bus.b = 8'h01;
            end
            if (bus.done) begin
                nd++;
                check("stream_spacing", cyc - last, 9);
                last = cyc;
                if (nd == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("stream_done_count", nd, 3);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'h0, bus.busy}, 0);
        check("reset_done", {31'h0, bus.done}, 0);
        check("reset_p", {16'h0, bus.p}, 0);
        rst_n = 1'b1;
        op(8'h0D, 8'h0B, 16'h008F, 0);
        op(8'hFF, 8'hFF, 16'hFE01, 0);
        op(8'h00, 8'hA5, 16'h0000, 0);
        op(8'h5A, 8'h00, 16'h0000, 0);
        op(8'hC8, 8'h07, 16'h0578, 1);
        op(8'h77, 8'h33, 16'h17B5, 2);
        op(8'h12, 8'h34, 16'h03A8, 0);
        stream();
        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
